// File: rtl/vending_sequencer_pkg.sv
// Shared definitions for the vending machine datapath: coin/item counts,
// coin values, item prices, controller state encoding and default timing.
package vending_machine_def;

  localparam int kNumCoins = 3;
  localparam int kNumItems = 4;

  localparam int unsigned kWaitTimeDefault = 32'd10;
  localparam int unsigned kMaxTotalDefault = 32'd10000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RETURN  = 2'd2
  } state_e;

  // Face value of coin index (bit position in the coin vectors).
  function automatic logic [31:0] coin_value(input int unsigned idx);
    case (idx)
      32'd0:   coin_value = 32'd100;
      32'd1:   coin_value = 32'd500;
      32'd2:   coin_value = 32'd1000;
      default: coin_value = 32'd0;
    endcase
  endfunction

  // Price of item index (bit position in the item vectors).
  function automatic logic [31:0] item_price(input int unsigned idx);
    case (idx)
      32'd0:   item_price = 32'd400;
      32'd1:   item_price = 32'd500;
      32'd2:   item_price = 32'd1000;
      32'd3:   item_price = 32'd2000;
      default: item_price = 32'd0;
    endcase
  endfunction

  // True when exactly one bit of an item select vector is set.
  function automatic logic is_onehot_item(input logic [kNumItems-1:0] v);
    is_onehot_item = (v != {kNumItems{1'b0}}) &&
                     ((v & (v - kNumItems'(1))) == {kNumItems{1'b0}});
  endfunction

endpackage

// File: rtl/vending_change_picker.sv
// Greedy change selector: given the remaining credit, picks the largest coin
// that does not exceed it and reports that coin one-hot plus its value.
module vending_change_picker
  import vending_machine_def::*;
#(
  parameter int TOTAL_W = 32
) (
  input  logic [TOTAL_W-1:0]   total_i,
  output logic [kNumCoins-1:0] coin_o,
  output logic [TOTAL_W-1:0]   value_o
);

  // Largest-first priority chain; nothing is picked below the smallest coin.
  always_comb begin
    coin_o  = {kNumCoins{1'b0}};
    value_o = {TOTAL_W{1'b0}};
    if (total_i >= TOTAL_W'(coin_value(32'd2))) begin
      coin_o  = 3'b100;
      value_o = TOTAL_W'(coin_value(32'd2));
    end else if (total_i >= TOTAL_W'(coin_value(32'd1))) begin
      coin_o  = 3'b010;
      value_o = TOTAL_W'(coin_value(32'd1));
    end else if (total_i >= TOTAL_W'(coin_value(32'd0))) begin
      coin_o  = 3'b001;
      value_o = TOTAL_W'(coin_value(32'd0));
    end else begin
      coin_o  = {kNumCoins{1'b0}};
      value_o = {TOTAL_W{1'b0}};
    end
  end

endmodule

// File: rtl/vending_sequencer.sv
// Vending machine controller: credits coins, runs the inactivity timer,
// grants single-item dispenses and returns change one coin per cycle.
// Optional build macro: VEND_AUTO_CHANGE_EN -- when defined, a dispense that
// leaves credit behind starts the change return immediately.
module vending_sequencer
  import vending_machine_def::*;
#(
  parameter int unsigned WAIT_TIME = kWaitTimeDefault,
  parameter int          TOTAL_W   = 32,
  parameter int unsigned MAX_TOTAL = kMaxTotalDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [kNumCoins-1:0] i_input_coin,
  input  logic [kNumItems-1:0] i_select_item,
  input  logic                 i_trigger_return,
  output logic [kNumItems-1:0] o_available_item,
  output logic [kNumItems-1:0] o_output_item,
  output logic [kNumCoins-1:0] o_return_coin,
  output logic [TOTAL_W-1:0]   o_current_total,
  output logic [TOTAL_W-1:0]   o_wait_time,
  output logic                 o_busy
);

  state_e               state_q, state_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic [TOTAL_W-1:0]   timer_q, timer_d;
  logic [kNumItems-1:0] avail_q, avail_d;
  logic [kNumItems-1:0] item_q, item_d;
  logic [kNumCoins-1:0] coin_q, coin_d;
  logic                 busy_q, busy_d;

  logic [TOTAL_W-1:0]   coin_sum;
  logic [TOTAL_W-1:0]   sel_price;
  logic                 credit;
  logic                 sel_ok;
  logic                 reload;
  logic                 ret_event;
  logic [TOTAL_W-1:0]   total_nx;
  logic [TOTAL_W-1:0]   pick_total;
  logic [kNumCoins-1:0] pick_coin;
  logic [TOTAL_W-1:0]   pick_val;

  // Deposit and selection evaluation against the pre-coin total.
  always_comb begin
    coin_sum  = {TOTAL_W{1'b0}};
    sel_price = {TOTAL_W{1'b0}};
    for (int i = 0; i < kNumCoins; i++) begin
      if (i_input_coin[i]) begin
        coin_sum = coin_sum + TOTAL_W'(coin_value(i));
      end else begin
        coin_sum = coin_sum;
      end
    end
    for (int i = 0; i < kNumItems; i++) begin
      if (i_select_item[i]) begin
        sel_price = sel_price | TOTAL_W'(item_price(i));
      end else begin
        sel_price = sel_price;
      end
    end
    credit = (state_q != ST_RETURN) && (coin_sum != {TOTAL_W{1'b0}}) &&
             ((total_q + coin_sum) <= TOTAL_W'(MAX_TOTAL));
    sel_ok = (state_q == ST_COLLECT) && is_onehot_item(i_select_item) &&
             (total_q >= sel_price);
    reload = credit || sel_ok;
    total_nx = total_q + (credit ? coin_sum : {TOTAL_W{1'b0}})
                       - (sel_ok ? sel_price : {TOTAL_W{1'b0}});
  end

  // On entry to RETURN the first coin comes from the freshly updated total;
  // inside RETURN it comes from the registered total.
  assign pick_total = (state_q == ST_RETURN) ? total_q : total_nx;

  vending_change_picker #(
    .TOTAL_W (TOTAL_W)
  ) u_change_picker (
    .total_i (pick_total),
    .coin_o  (pick_coin),
    .value_o (pick_val)
  );

  // Next-state and registered-output logic of the controller FSM.
  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    timer_d   = timer_q;
    item_d    = {kNumItems{1'b0}};
    coin_d    = {kNumCoins{1'b0}};
    busy_d    = 1'b0;
    ret_event = 1'b0;
    case (state_q)
      ST_IDLE: begin
        total_d = total_nx;
        if (credit) begin
          state_d = ST_COLLECT;
          timer_d = TOTAL_W'(WAIT_TIME);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        total_d = total_nx;
        item_d  = sel_ok ? i_select_item : {kNumItems{1'b0}};
        if (reload) begin
          timer_d = TOTAL_W'(WAIT_TIME);
        end else if (timer_q != {TOTAL_W{1'b0}}) begin
          timer_d = timer_q - TOTAL_W'(1);
        end else begin
          timer_d = {TOTAL_W{1'b0}};
        end
`ifdef VEND_AUTO_CHANGE_EN
        ret_event = i_trigger_return ||
                    (!reload && (timer_q == {TOTAL_W{1'b0}})) ||
                    (sel_ok && (total_nx != {TOTAL_W{1'b0}}));
`else
        ret_event = i_trigger_return ||
                    (!reload && (timer_q == {TOTAL_W{1'b0}}));
`endif
        if (ret_event && (total_nx != {TOTAL_W{1'b0}})) begin
          state_d = ST_RETURN;
          timer_d = {TOTAL_W{1'b0}};
          coin_d  = pick_coin;
          total_d = total_nx - pick_val;
          busy_d  = 1'b1;
        end else if (ret_event) begin
          state_d = ST_IDLE;
          timer_d = {TOTAL_W{1'b0}};
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_RETURN: begin
        timer_d = {TOTAL_W{1'b0}};
        if ((total_q != {TOTAL_W{1'b0}}) && (pick_coin != {kNumCoins{1'b0}})) begin
          coin_d  = pick_coin;
          total_d = total_q - pick_val;
          busy_d  = 1'b1;
        end else begin
          // Remainder below the smallest coin cannot be paid out; drop it.
          state_d = ST_IDLE;
          total_d = {TOTAL_W{1'b0}};
        end
      end
      default: begin
        state_d = ST_IDLE;
        total_d = {TOTAL_W{1'b0}};
        timer_d = {TOTAL_W{1'b0}};
      end
    endcase
  end

  // Availability mirrors the registered total one cycle later, blanked in RETURN.
  always_comb begin
    avail_d = {kNumItems{1'b0}};
    for (int i = 0; i < kNumItems; i++) begin
      if (state_d != ST_RETURN) begin
        avail_d[i] = (total_q >= TOTAL_W'(item_price(i)));
      end else begin
        avail_d[i] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      total_q <= {TOTAL_W{1'b0}};
      timer_q <= {TOTAL_W{1'b0}};
      avail_q <= {kNumItems{1'b0}};
      item_q  <= {kNumItems{1'b0}};
      coin_q  <= {kNumCoins{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      timer_q <= timer_d;
      avail_q <= avail_d;
      item_q  <= item_d;
      coin_q  <= coin_d;
      busy_q  <= busy_d;
    end
  end

  assign o_available_item = avail_q;
  assign o_output_item    = item_q;
  assign o_return_coin    = coin_q;
  assign o_current_total  = total_q;
  assign o_wait_time      = timer_q;
  assign o_busy           = busy_q;

endmodule

// File: doc/vending_sequencer.md
Name: vending_sequencer

Overview:
- Top-level controller for the vending machine datapath. Tracks the deposited total, arms and decrements the coin-return wait timer, and grants item dispense.
- Sequences change return as a greedy one-coin-per-cycle burst: 1000, then 500, then 100.
- Sits between the coin and select inputs and the item and coin output ports. Replaces the ad-hoc combinational return logic with a single clocked FSM.

Parameters:
- WAIT_TIME, 10, cycles of inactivity before automatic return.
- TOTAL_W, 32, width of total and timer registers.
- MAX_TOTAL, 10000, credit ceiling; a coin that would exceed it is not credited.
- Shared package constants: coin values 100/500/1000 and item prices 400/500/1000/2000.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- i_input_coin  in  kNumCoins(3)  one bit per coin (bit0=100, bit1=500, bit2=1000), one-cycle pulse per coin
- i_select_item  in  kNumItems(4)  one bit per item, one-cycle pulse
- i_trigger_return  in  1  user return request, one-cycle pulse
- o_available_item  out  kNumItems  bit i = (total >= price[i]), registered
- o_output_item  out  kNumItems  one-hot dispense pulse, 1 cycle
- o_return_coin  out  kNumCoins  one-hot, one coin per cycle during RETURN
- o_current_total  out  TOTAL_W  current credit
- o_wait_time  out  TOTAL_W  remaining timer
- o_busy  out  1  high in RETURN; coins and selects are ignored

Behaviour:
- Reset (synchronous, active-high): state=IDLE, total=0, timer=0, all outputs 0. Applies mid-RETURN; coins not yet returned are discarded.
- States: IDLE, COLLECT, RETURN.
- Coin credit:
  - Each set bit of i_input_coin adds its value in the same cycle; multiple bits are summed.
  - If the resulting sum would exceed MAX_TOTAL, the whole cycle's deposit is rejected and the total is unchanged.
  - A credited coin reloads the timer to WAIT_TIME.
- IDLE -> COLLECT on any credited coin.
- Select rules in COLLECT:
  - Valid only if exactly one bit is set and total >= price. Then o_output_item = that bit for 1 cycle, total -= price (registered), timer reloaded.
  - Multi-bit or unaffordable selects are ignored: no output, total and timer unchanged.
- Coin plus select in the same cycle: the affordability check uses the pre-coin total; both updates apply (total + coin - price).
- Timer:
  - Decrements by 1 per cycle in COLLECT while >0, saturating at 0.
  - Reload takes priority over decrement.
- COLLECT -> RETURN when timer reaches 0, or on i_trigger_return, if total > 0.
- COLLECT -> IDLE if total == 0 at either of those events.
- i_trigger_return in IDLE: no effect.
- RETURN:
  - o_busy=1. Each cycle emit the largest coin <= total on o_return_coin and subtract its value.
  - Go to IDLE the cycle after total reaches 0; o_return_coin=0 in IDLE.
  - Latency = number of coins returned; e.g. total 1600 gives 3 cycles (1000, 500, 100).
  - Inputs during RETURN are dropped (upstream must honour o_busy).
- Width rules:
  - All arithmetic is unsigned TOTAL_W; the subtractions cannot underflow by construction.
  - Totals are always multiples of 100.
- o_available_item updates one cycle after the total changes; it is forced to 0 during RETURN.

Optional Feature:
- VEND_AUTO_CHANGE_EN.
- Defined: after a valid dispense with a nonzero remainder, the FSM enters RETURN on the next cycle without waiting for the timer.
- Undefined: it stays in COLLECT with the timer reloaded, allowing further purchases.

Decomposition:
- Shared package, vending_machine_def: kNumCoins, kNumItems, coin value array, item price array, state encoding, WAIT_TIME default.
- One natural sub-module, vending_change_picker: combinational greedy selector (total -> one-hot coin, coin value).

Test Plan:
- 1000 coin, then select item1 (500) -> o_output_item=4'b0010 for 1 cycle, total 1000->500, timer reloaded to 10.
- 500 coin, no activity -> timer counts 10..0, then RETURN emits 3'b010 for 1 cycle, total=0, IDLE.
- Coins 1000+500+100 (total 1600), i_trigger_return -> o_return_coin sequence 100b, 010b, 001b over 3 cycles, o_busy high 3 cycles.
- 100 coin, select item0 (400) -> no dispense, total stays 100; select 4'b0011 with total 1000 -> ignored.
- Reset asserted mid-RETURN (total 1500, after first coin) -> next cycle total=0, o_return_coin=0, IDLE.
- Total 9500, 1000 coin -> deposit rejected, total stays 9500. Same-cycle 500 coin + item0 select at total 400 -> dispense, total 500.
